fifo_pkt_reader: RTL and testbench

- Read-side drain engine for the dual-clock 4k x 18 FIFO. Sits in the FIFO read-clock domain.
- Waits until a full packet of PKT_LEN words is buffered, then bursts it out to a downstream consumer on a valid/ready stream.
- Checks the framing flags carried in FIFO bits 17:16 and counts delivered packets.

---
 rtl/fifo_pkt_reader.sv | 182 ++++++++++++++++++
 tb/tb_fifo_pkt_reader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: read-side drain engine for the dual-clock packet FIFO.
// Waits for a full packet, bursts it out on a valid/ready stream.
//
// Ports:
//   clock, reset_n        read-domain clock, async active-low reset
//   clear                 sync abort: idle, flush skid, clear sticky flags
//   fifo_q/rdempty/rdusedw FIFO read side ({eop, sop, payload})
//   fifo_rdreq            FIFO read strobe (non-show-ahead, 1-cycle data)
//   out_data/sop/eop      payload and position-derived framing
//   out_valid/out_ready   downstream handshake
//   frame_err, underrun   sticky status
//   pkt_count             packets fully delivered (wraps)
module fifo_pkt_reader #(
   parameter int WIDTH      = 16,
   parameter int PKT_LEN    = 256,
   parameter int USEDW_BITS = 12
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic [WIDTH+1:0]      fifo_q,
   input  logic                  fifo_rdempty,
   input  logic [USEDW_BITS-1:0] fifo_rdusedw,
   output logic                  fifo_rdreq,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_sop,
   output logic                  out_eop,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  frame_err,
   output logic                  underrun,
   output logic [15:0]           pkt_count
);

   localparam logic [USEDW_BITS-1:0] LEN  =
      USEDW_BITS'(PKT_LEN);
   localparam logic [USEDW_BITS-1:0] LAST =
      USEDW_BITS'(PKT_LEN - 1);

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   state_t state;
   state_t state_nx;

   logic [USEDW_BITS-1:0] req_cnt;
   logic [USEDW_BITS-1:0] cap_cnt;
   logic [USEDW_BITS-1:0] pos;
   logic [1:0]            occ;
   logic                  in_flight;
   logic [WIDTH-1:0]      skid0;
   logic [WIDTH-1:0]      skid1;

   logic       acc;
   logic       cap;
   logic       eop_acc;
   logic       room;
   logic [1:0] held;

   // skid0 is the output register; skid1 absorbs the
   // in-flight word when the consumer stalls.
   assign out_valid = (occ != 2'd0);
   assign out_data  = skid0;
   assign out_sop   = out_valid && (pos == '0);
   assign out_eop   = out_valid && (pos == LAST);

   assign acc     = out_valid && out_ready;
   assign cap     = in_flight;
   assign eop_acc = acc && (pos == LAST);

   // Words held or owed. A word leaving this cycle frees
   // its slot, which keeps the burst at one word per clock.
   assign held = occ + {1'b0, in_flight};
   assign room = acc || (held < 2'd2);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      fifo_rdreq = 1'b0;
      if (clear) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (fifo_rdusedw >= LEN)
                  state_nx = BURST;
            end
            BURST: begin
               fifo_rdreq = (req_cnt < LEN)
                          && !fifo_rdempty
                          && room;
               if (eop_acc)
                  state_nx = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         req_cnt   <= '0;
         cap_cnt   <= '0;
         pos       <= '0;
         occ       <= 2'd0;
         in_flight <= 1'b0;
         skid0     <= '0;
         skid1     <= '0;
         frame_err <= 1'b0;
         underrun  <= 1'b0;
         pkt_count <= '0;
      end else if (clear) begin
         // The in-flight word shows up on fifo_q now and
         // is simply not captured.
         req_cnt   <= '0;
         cap_cnt   <= '0;
         pos       <= '0;
         occ       <= 2'd0;
         in_flight <= 1'b0;
         frame_err <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         in_flight <= fifo_rdreq;
         if (fifo_rdreq)
            req_cnt <= req_cnt + 1'b1;

         // Flags are only checked, never used for framing.
         if (cap) begin
            cap_cnt <= cap_cnt + 1'b1;
            if ((fifo_q[WIDTH] != (cap_cnt == '0)) ||
                (fifo_q[WIDTH+1] != (cap_cnt == LAST)))
               frame_err <= 1'b1;
         end

         unique case ({acc, cap})
            2'b01: begin
               if (occ == 2'd0)
                  skid0 <= fifo_q[WIDTH-1:0];
               else
                  skid1 <= fifo_q[WIDTH-1:0];
               occ <= occ + 2'd1;
            end
            2'b10: begin
               skid0 <= skid1;
               occ   <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd2) begin
                  skid0 <= skid1;
                  skid1 <= fifo_q[WIDTH-1:0];
               end else begin
                  skid0 <= fifo_q[WIDTH-1:0];
               end
            end
            default: ;
         endcase

         if (acc)
            pos <= pos + 1'b1;

         if (state == BURST && req_cnt < LEN &&
             fifo_rdempty && occ == 2'd0)
            underrun <= 1'b1;

         if (eop_acc) begin
            pkt_count <= pkt_count + 16'd1;
            req_cnt   <= '0;
            cap_cnt   <= '0;
            pos       <= '0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// tb_fifo_pkt_reader: directed bench for fifo_pkt_reader
// with a behavioural non-show-ahead FIFO in front of it.
module tb_fifo_pkt_reader;

   localparam int W  = 16;
   localparam int L  = 256;
   localparam int UB = 12;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          clear = 1'b0;
   logic [W+1:0]  fifo_q = '0;
   logic          fifo_rdempty = 1'b1;
   logic [UB-1:0] fifo_rdusedw = '0;
   logic          fifo_rdreq;
   logic [W-1:0]  out_data;
   logic          out_sop;
   logic          out_eop;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          frame_err;
   logic          underrun;
   logic [15:0]   pkt_count;

   fifo_pkt_reader #(
      .WIDTH(W),
      .PKT_LEN(L),
      .USEDW_BITS(UB)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .clear(clear),
      .fifo_q(fifo_q),
      .fifo_rdempty(fifo_rdempty),
      .fifo_rdusedw(fifo_rdusedw),
      .fifo_rdreq(fifo_rdreq),
      .out_data(out_data),
      .out_sop(out_sop),
      .out_eop(out_eop),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .frame_err(frame_err),
      .underrun(underrun),
      .pkt_count(pkt_count)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;

   logic [W+1:0] fq[$];
   logic [W+1:0] got[$];
   int           got_cyc[$];
   int           cyc = 0;
   int           outs = 0;
   int           cnt_rd = 0;
   int           cnt_val = 0;
   int           v_rd_empty = 0;
   int           v_outs = 0;
   int           v_hold = 0;
   bit           force_empty = 1'b0;
   bit           rnd_ready = 1'b0;
   bit           p_stall = 1'b0;
   logic [W+1:0] p_word = '0;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_fifo();
      int n;
      n = fq.size();
      fifo_rdempty = force_empty || (n == 0);
      fifo_rdusedw = UB'((n > 4095) ? 4095 : n);
   endtask

   function automatic logic [W+1:0] mkw(input int base,
                                         input int i);
      logic [W-1:0] d;
      d = W'(base + i);
      return {(i == L - 1), (i == 0), d};
   endfunction

   task automatic load(input int base, input int bad);
      logic [W+1:0] w;
      for (int i = 0; i < L; i++) begin
         w = mkw(base, i);
         if (i == bad)
            w[W] = 1'b1;
         fq.push_back(w);
      end
      drive_fifo();
   endtask

   task automatic tick();
      logic s_rd;
      logic s_acc;
      logic s_clr;
      logic [W+1:0] s_word;
      @(negedge clock);
      s_rd   = fifo_rdreq;
      s_acc  = out_valid && out_ready;
      s_clr  = clear;
      s_word = {out_eop, out_sop, out_data};
      if (s_rd) cnt_rd++;
      if (out_valid) cnt_val++;
      if (s_rd && fifo_rdempty) v_rd_empty++;
      if (s_rd && !s_acc && outs >= 2) v_outs++;
      if (p_stall && (!out_valid || s_word !== p_word))
         v_hold++;
      p_stall = out_valid && !out_ready && !clear && reset_n;
      p_word  = s_word;
      if (s_acc && !s_clr) begin
         got.push_back(s_word);
         got_cyc.push_back(cyc);
      end
      @(posedge clock);
      #1;
      if (s_rd) begin
         outs++;
         if (fq.size() > 0)
            fifo_q = fq.pop_front();
      end
      if (s_acc) outs--;
      if (s_clr) outs = 0;
      cyc++;
      if (rnd_ready)
         out_ready = ($urandom_range(1, 0) == 1);
      drive_fifo();
   endtask

   task automatic run_until(input int n, input int budget);
      int k;
      k = 0;
      while (got.size() < n && k < budget) begin
         tick();
         k++;
      end
   endtask

   task automatic chk_pkt(input string tag, input int start,
                          input int base, input int n);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         if (start + i >= got.size())
            bad++;
         else if (got[start+i] !== mkw(base, i))
            bad++;
      end
      chk(tag, bad, 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rdreq"}, fifo_rdreq, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_sop"}, out_sop, 0);
      chk({tag, "_eop"}, out_eop, 0);
      chk({tag, "_ferr"}, frame_err, 0);
      chk({tag, "_urun"}, underrun, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_pkts"}, pkt_count, 0);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      out_ready = 1'b0;
      tick();
      clear = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      int span;
      int r0;
      int k;
      int v1;

      drive_fifo();
      #12;
      chk_reset("rst");
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      // full good packet, ready held high
      load(0, -1);
      out_ready = 1'b1;
      run_until(L, 600);
      chk("t1_count", got.size(), L);
      chk_pkt("t1_data", 0, 0, L);
      span = (got_cyc.size() >= L) ?
             got_cyc[L-1] - got_cyc[0] : -1;
      chk("t1_span", span, L - 1);
      chk("t1_pkts", pkt_count, 1);
      chk("t1_ferr", frame_err, 0);
      chk("t1_urun", underrun, 0);

      // one word short: stay idle, then start
      got.delete();
      got_cyc.delete();
      for (int i = 0; i < L - 1; i++)
         fq.push_back(mkw(16'h1000, i));
      drive_fifo();
      r0 = cnt_rd;
      v1 = cnt_val;
      repeat (20) tick();
      chk("t2_idle_rd", cnt_rd - r0, 0);
      chk("t2_idle_val", cnt_val - v1, 0);
      fq.push_back(mkw(16'h1000, L - 1));
      drive_fifo();
      r0 = cnt_rd;
      k = 0;
      while (cnt_rd == r0 && k < 3) begin
         tick();
         k++;
      end
      chk("t2_start", k, 2);
      run_until(L, 600);
      chk("t2_count", got.size(), L);
      chk_pkt("t2_data", 0, 16'h1000, L);
      chk("t2_pkts", pkt_count, 2);

      // three packets under random backpressure
      got.delete();
      got_cyc.delete();
      load(16'h2000, -1);
      load(16'h2100, -1);
      load(16'h2200, -1);
      rnd_ready = 1'b1;
      run_until(3 * L, 5000);
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      chk("t3_count", got.size(), 3 * L);
      chk_pkt("t3_pkt0", 0, 16'h2000, L);
      chk_pkt("t3_pkt1", L, 16'h2100, L);
      chk_pkt("t3_pkt2", 2 * L, 16'h2200, L);
      chk("t3_pkts", pkt_count, 5);
      chk("t3_outstanding", v_outs, 0);

      // bad sop flag on word 10
      got.delete();
      got_cyc.delete();
      load(16'h3000, 10);
      run_until(L, 600);
      chk("t4_count", got.size(), L);
      chk_pkt("t4_data", 0, 16'h3000, L);
      chk("t4_ferr", frame_err, 1);
      chk("t4_pkts", pkt_count, 6);
      pulse_clear();
      chk("t4_ferr_clr", frame_err, 0);
      chk("t4_pkts_kept", pkt_count, 6);

      // FIFO runs dry at word 100 for 20 cycles
      got.delete();
      got_cyc.delete();
      load(16'h4000, -1);
      run_until(100, 400);
      chk("t5_urun0", underrun, 0);
      force_empty = 1'b1;
      drive_fifo();
      repeat (10) tick();
      v1 = cnt_val;
      repeat (10) tick();
      chk("t5_stall", cnt_val - v1, 0);
      chk("t5_urun", underrun, 1);
      force_empty = 1'b0;
      drive_fifo();
      run_until(L, 600);
      chk("t5_count", got.size(), L);
      chk_pkt("t5_data", 0, 16'h4000, L);
      chk("t5_pkts", pkt_count, 7);
      chk("t5_urun_sticky", underrun, 1);
      pulse_clear();
      chk("t5_urun_clr", underrun, 0);

      // clear at word 50 with a read in flight
      got.delete();
      got_cyc.delete();
      load(16'h5000, -1);
      run_until(50, 300);
      pulse_clear();
      fq.delete();
      drive_fifo();
      repeat (5) tick();
      chk("t6_abandon_cnt", got.size(), 50);
      chk_pkt("t6_partial", 0, 16'h5000, 50);
      chk("t6_valid", out_valid, 0);
      chk("t6_pkts_kept", pkt_count, 7);
      got.delete();
      got_cyc.delete();
      load(16'h6000, -1);
      run_until(L, 600);
      chk("t6_count", got.size(), L);
      chk_pkt("t6_data", 0, 16'h6000, L);
      chk("t6_pkts", pkt_count, 8);
      chk("t6_ferr", frame_err, 0);

      // async reset mid-burst
      got.delete();
      got_cyc.delete();
      load(16'h7000, -1);
      run_until(30, 200);
      chk("t7_mid", out_valid, 1);
      reset_n = 1'b0;
      p_stall = 1'b0;
      #2;
      chk_reset("t7_rst");
      fq.delete();
      outs = 0;
      drive_fifo();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      p_stall = 1'b0;
      repeat (4) tick();
      chk("t7_idle_valid", out_valid, 0);

      chk("rdreq_when_empty", v_rd_empty, 0);
      chk("outstanding", v_outs, 0);
      chk("hold_stable", v_hold, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
